// File: rtl/titan_if_stage_pkg.sv
// Titan shared definitions: PC-select encodings and fetch constants.
// Imported by the fetch stage and its bench.
package titan_defines;

    localparam logic [1:0] PC_SEL_SEQ    = 2'b00;
    localparam logic [1:0] PC_SEL_BRANCH = 2'b01;
    localparam logic [1:0] PC_SEL_JUMP   = 2'b10;
    localparam logic [1:0] PC_SEL_EXC    = 2'b11;

    localparam logic [31:0] TITAN_RESET_ADDR = 32'h8000_0000;
    localparam logic [31:0] TITAN_NOP        = 32'h0000_0013;

endpackage

// File: rtl/titan_if_stage_if.sv
// Wishbone-classic instruction bus between fetch stage and memory.
// Master drives address and strobes; slave returns data, ack, err.
interface titan_wb_if;

    logic [31:0] addr;
    logic        cyc;
    logic        stb;
    logic [31:0] dat;
    logic        ack;
    logic        err;

    modport master (
        output addr, cyc, stb,
        input  dat, ack, err
    );

    modport slave (
        input  addr, cyc, stb,
        output dat, ack, err
    );

endinterface

// File: rtl/titan_if_stage.sv
// Titan instruction-fetch stage: PC mux, single-outstanding
// Wishbone fetch FSM and registered IF/ID output.
module titan_if_stage
    import titan_defines::*;
#(
    parameter logic [31:0] RESET_ADDR = TITAN_RESET_ADDR,
    parameter logic [31:0] NOP        = TITAN_NOP
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        if_stall_i,
    input  logic        if_kill_i,
    input  logic        if_flush_i,
    input  logic [1:0]  if_pc_sel_i,
    input  logic [31:0] branch_target_i,
    input  logic [31:0] jump_target_i,
    input  logic [31:0] exception_pc_i,
    titan_wb_if.master  iwbm,
    output logic        if_stall_req_o,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_instruction_o,
    output logic        if_valid_o,
    output logic        if_bus_fault_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_HOLD,
        S_DISCARD
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_target;
    logic [31:0] r_instr;
    logic [31:0] r_out_pc;
    logic        r_valid;
    logic        r_fault;

    logic        w_resp;
    logic        w_redir;
    logic        w_evt;
    logic        w_busy;
    logic [31:0] w_pc_inc;
    logic [31:0] w_sel_tgt;
    logic [31:0] w_target;

    assign w_resp   = iwbm.ack | iwbm.err;
    assign w_pc_inc = r_pc + 32'd4;
    assign w_busy   = (r_state == S_REQ) | (r_state == S_DISCARD);

    assign w_redir = (if_pc_sel_i == PC_SEL_EXC)
                   | (if_kill_i & ((if_pc_sel_i == PC_SEL_BRANCH)
                                 | (if_pc_sel_i == PC_SEL_JUMP)));
    assign w_evt   = w_redir | if_kill_i;

    always_comb begin
        w_sel_tgt = w_pc_inc;
        unique case (if_pc_sel_i)
            PC_SEL_BRANCH: w_sel_tgt = branch_target_i;
            PC_SEL_JUMP:   w_sel_tgt = jump_target_i;
            PC_SEL_EXC:    w_sel_tgt = exception_pc_i;
            default:       w_sel_tgt = w_pc_inc;
        endcase
    end

    // A bare kill skips the squashed slot and continues sequentially.
    assign w_target = (w_redir ? w_sel_tgt : w_pc_inc) & ~32'd3;

    assign iwbm.addr = r_pc;
    assign iwbm.cyc  = w_busy;
    assign iwbm.stb  = w_busy;

    assign if_stall_req_o = ~(rst_i | if_flush_i)
                          & ((r_state == S_IDLE) | (w_busy & ~w_resp));

    assign if_pc_o          = r_out_pc;
    assign if_instruction_o = r_instr;
    assign if_valid_o       = r_valid;
    assign if_bus_fault_o   = r_fault;

    always_ff @(posedge clk_i) begin
        if (rst_i || if_flush_i) begin
            r_state  <= S_IDLE;
            r_pc     <= RESET_ADDR;
            r_target <= RESET_ADDR;
            r_instr  <= NOP;
            r_out_pc <= RESET_ADDR;
            r_valid  <= 1'b0;
            r_fault  <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    r_state <= S_REQ;
                    r_valid <= 1'b0;
                    if (w_redir)
                        r_pc <= w_target;
                end
                S_REQ: begin
                    if (w_evt) begin
                        r_valid <= 1'b0;
                        if (w_resp) begin
                            r_pc <= w_target;
                        end else begin
                            r_target <= w_target;
                            r_state  <= S_DISCARD;
                        end
                    end else if (w_resp) begin
                        r_instr  <= iwbm.err ? NOP : iwbm.dat;
                        r_fault  <= iwbm.err;
                        r_valid  <= 1'b1;
                        r_out_pc <= r_pc;
                        if (!if_stall_i)
                            r_pc <= w_pc_inc;
                        else
                            r_state <= S_HOLD;
                    end else if (!if_stall_i) begin
                        r_valid <= 1'b0;
                    end
                end
                S_HOLD: begin
                    if (w_evt) begin
                        r_valid <= 1'b0;
                        r_pc    <= w_target;
                        r_state <= S_REQ;
                    end else if (!if_stall_i) begin
                        r_valid <= 1'b0;
                        r_pc    <= w_pc_inc;
                        r_state <= S_REQ;
                    end
                end
                S_DISCARD: begin
                    // Old fetch must complete on the bus before redirecting.
                    r_valid <= 1'b0;
                    if (w_resp) begin
                        r_pc    <= w_evt ? w_target : r_target;
                        r_state <= S_REQ;
                    end else if (w_evt) begin
                        r_target <= w_target;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
